seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 27 ++
 rtl/hex_seg_decode.sv | 33 +++
 rtl/seg7_scan_driver.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan driver.
//   - SEG_0..SEG_F : active-low glyphs, bit order [0:6] = a..g (index 0 = a)
//   - SEG_BLANK    : all segments off
//   - REFRESH_DIV_DEFAULT : default clk cycles per digit slot
package seg7_pkg;

    localparam int unsigned REFRESH_DIV_DEFAULT = 50000;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0001100;
    localparam logic [0:6] SEG_A     = 7'b0001000;
    localparam logic [0:6] SEG_B     = 7'b1100000;
    localparam logic [0:6] SEG_C     = 7'b0110001;
    localparam logic [0:6] SEG_D     = 7'b1000010;
    localparam logic [0:6] SEG_E     = 7'b0110000;
    localparam logic [0:6] SEG_F     = 7'b0111000;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: combinational hex nibble to active-low 7-segment glyph.
//   nibble : in  [3:0] hex digit
//   glyph  : out [0:6] segments a..g, active-low
module hex_seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [0:6] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        unique case (nibble)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a common-anode 7-segment bank.
// New values are staged in a pending register and promoted to the displayed
// (active) register only at a frame boundary, or at once while disabled.
//   clk        : in  system clock
//   rst_n      : in  synchronous active-low reset
//   enable     : in  1 = scan, 0 = blank and hold scan at digit 0
//   load       : in  1-cycle strobe capturing value/dp_in into pending
//   value      : in  packed nibbles, nibble i drives digit i (digit 0 rightmost)
//   dp_in      : in  decimal point per digit, 1 = lit
//   seg        : out [0:6] segments a..g, active-low
//   dp         : out decimal point, active-low
//   an         : out digit enables, active-low
//   frame_done : out 1-cycle pulse after the last digit's slot ends
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT,
    parameter int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [0:6]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                pend_q, pend_d;
    logic [0:6]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                fd_q, fd_d;

    logic                slot_end, last_digit, boundary, promote;
    logic [3:0]          sel_nib;
    logic                sel_dp, sel_blank;
    logic [0:6]          glyph;
    logic [DIGITS-1:0]   lz_mask;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_q     <= 1'b0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= '1;
            fd_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_q     <= pend_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            fd_q       <= fd_d;
        end
    end

    // Next-state: scan counters and pending/active staging
    always_comb begin
        slot_end   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        last_digit = (idx_q == IDX_W'(DIGITS - 1));
        boundary   = enable && slot_end && last_digit;

        cnt_d = '0;
        idx_d = '0;
        if (enable) begin
            cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
            idx_d = idx_q;
            if (slot_end) begin
                idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
            end
        end

        // Promotion uses the older pending value; a same-cycle load re-arms pending.
        promote    = pend_q && (boundary || !enable);
        act_val_d  = promote ? pend_val_q : act_val_q;
        act_dp_d   = promote ? pend_dp_q : act_dp_q;
        pend_val_d = load ? value : pend_val_q;
        pend_dp_d  = load ? dp_in : pend_dp_q;
        pend_d     = load || (pend_q && !promote);
        fd_d       = boundary;
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // lz_mask[i] set when nibble i and every higher nibble are zero; digit 0 exempt.
    always_comb begin
        logic higher_zero;
        higher_zero = 1'b1;
        lz_mask     = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            higher_zero = higher_zero && (act_val_q[4*i +: 4] == 4'h0);
            lz_mask[i]  = higher_zero;
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Select the current digit's nibble, dp and blanking bit
    always_comb begin
        sel_nib   = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nib   = act_val_q[4*i +: 4];
                sel_dp    = act_dp_q[i];
                sel_blank = lz_mask[i];
            end
        end
    end

    hex_seg_decode u_decode (
        .nibble (sel_nib),
        .glyph  (glyph)
    );

    // Output next-state: registered so a slot appears one cycle after idx changes
    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
        if (enable) begin
            seg_d = sel_blank ? SEG_BLANK : glyph;
            dp_d  = ~sel_dp;
            for (int i = 0; i < int'(DIGITS); i++) begin
                an_d[i] = (idx_q != IDX_W'(i));
            end
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int NDIG  = 4;
    localparam int RD    = 4;
    localparam int FRAME = NDIG * RD;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [0:6]  seg_w;
    logic        dp_w;
    logic [3:0]  an_w;
    logic        fd_w;

    seg7_scan_driver #(
        .DIGITS      (NDIG),
        .REFRESH_DIV (RD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .seg        (seg_w),
        .dp         (dp_w),
        .an         (an_w),
        .frame_done (fd_w)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e, mon_a;

    // Reference model: position within the frame plus displayed/pending data
    int          pos = 0;
    logic [15:0] act_v = '0, pend_v = '0;
    logic [3:0]  act_dp = '0, pend_dp = '0;
    bit          pend = 1'b0;
    logic        en_lvl = 1'b1;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0001100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic exp_t model_out(input logic r, input logic e);
        exp_t o;
        int   digit;
        o.seg = 7'b1111111;
        o.dp  = 1'b1;
        o.an  = 4'b1111;
        o.fd  = 1'b0;
        if (r && e) begin
            digit = pos / RD;
            o.seg = font(4'(act_v >> (4 * digit)));
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (digit > 0 && (act_v >> (4 * digit)) == 16'h0) o.seg = 7'b1111111;
`endif
            o.dp = ~act_dp[digit];
            o.an = ~(4'b0001 << digit);
            o.fd = (pos == FRAME - 1);
        end
        return o;
    endfunction

    task automatic step(input logic r, input logic e, input logic l,
                        input logic [15:0] v, input logic [3:0] d);
        bit bnd;
        @(negedge clk);
        #1;
        rst_n  = r;
        enable = e;
        load   = l;
        value  = v;
        dp_in  = d;
        exp_q.push_back(model_out(r, e));
        if (!r) begin
            pos = 0; act_v = '0; act_dp = '0; pend_v = '0; pend_dp = '0; pend = 1'b0;
        end else begin
            bnd = e && (pos == FRAME - 1);
            pos = e ? (pos + 1) % FRAME : 0;
            if (pend && (bnd || !e)) begin
                act_v = pend_v; act_dp = pend_dp; pend = 1'b0;
            end
            if (l) begin
                pend_v = v; pend_dp = d; pend = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, en_lvl, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        step(1'b1, en_lvl, 1'b1, v, d);
    endtask

    task automatic run_to(input int p);
        for (int k = 0; k < 2 * FRAME && pos != p; k++) idle(1);
    endtask

    // Monitor: outputs are valid every cycle; compare one expectation per cycle
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {seg_w, dp_w, an_w, fd_w};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got seg=%b dp=%b an=%b fd=%b want seg=%b dp=%b an=%b fd=%b",
                         cyc, mon_a.seg, mon_a.dp, mon_a.an, mon_a.fd,
                         mon_e.seg, mon_e.dp, mon_e.an, mon_e.fd);
            end
        end
    end

    initial begin
        // Reset held 3 cycles, then release with enable=1
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        en_lvl = 1'b1;
        idle(20);

        // Scan a known value
        do_load(16'h12AF, 4'b0101);
        idle(3 * FRAME);

        // Tear-free update: 1111 overwritten by 2222 mid-frame
        run_to(5);
        do_load(16'h1111, 4'b0000);
        run_to(9);
        do_load(16'h2222, 4'b1000);
        idle(2 * FRAME);

        // Load on the boundary cycle itself, with an older pending value waiting
        run_to(3);
        do_load(16'h3456, 4'b0010);
        run_to(FRAME - 1);
        do_load(16'h789C, 4'b0001);
        idle(3 * FRAME);

        // Disable mid-frame, load while disabled, then re-enable
        run_to(6);
        en_lvl = 1'b0;
        idle(2);
        do_load(16'hBEEF, 4'b1111);
        idle(3);
        en_lvl = 1'b1;
        idle(2 * FRAME);

        // Reset mid-frame abandons the frame
        run_to(10);
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        idle(FRAME + 4);

        // Leading-zero cases
        do_load(16'h0050, 4'b0000);
        idle(2 * FRAME + 2);
        do_load(16'h0000, 4'b0000);
        idle(2 * FRAME + 2);

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            logic r, l;
            r = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 39) == 0) en_lvl = ~en_lvl;
            l = ($urandom_range(0, 7) == 0);
            step(r, en_lvl, l, 16'($urandom), 4'($urandom));
        end

        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
